// File: rtl/dmem_access_ctrl.sv
// Load/store front-end for a single-port 16K x 32 data memory with 1-cycle read latency.
// Formats sub-word loads, performs sub-word stores as read-modify-write, flags misaligned requests.
module dmem_access_ctrl #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              ld_valid,
  output logic [DATA_W-1:0] ld_data,
  output logic              err_misalign,
  output logic              dm_en,
  output logic              dm_we,
  output logic [ADDR_W-3:0] dm_addr,
  output logic [DATA_W-1:0] dm_wdata,
  input  logic [DATA_W-1:0] dm_rdata,
  output logic [CNT_W-1:0]  cnt_load,
  output logic [CNT_W-1:0]  cnt_store,
  output logic [CNT_W-1:0]  cnt_rmw,
  output logic [CNT_W-1:0]  cnt_misalign,
  output logic [1:0]        dbg_state
);

  localparam int WA = ADDR_W - 2;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LD_WAIT = 2'd1,
    RMW_WR  = 2'd2
  } state_t;

  state_t state, state_nx;

  logic [WA-1:0] lat_addr;
  logic [1:0]    lat_off;
  logic [1:0]    lat_size;
  logic          lat_uns;
  logic [15:0]   lat_wdata;

  logic          accept;
  logic          misalign;
  logic          word_store;
  logic [DATA_W-1:0] lane_sh;
  logic [DATA_W-1:0] ld_fmt;
  logic [DATA_W-1:0] rmw_data;

  // Handshake: a request transfers on a posedge where req_valid && req_ready; ready only in IDLE.
  assign req_ready  = (state == IDLE);
  assign accept     = req_valid && req_ready;
  assign misalign   = (req_size == 2'b11) ||
                      (req_size == 2'b01 && req_addr[0]) ||
                      (req_size == 2'b10 && req_addr[1:0] != 2'b00);
  assign word_store = req_we && (req_size == 2'b10);
  assign dbg_state  = state;

  // Lane select for loads: shift the addressed byte/half down to bit 0, then extend.
  assign lane_sh = dm_rdata >> {lat_off, 3'b000};

  always_comb begin
    ld_fmt = dm_rdata;
    case (lat_size)
      2'b00:   ld_fmt = lat_uns ? {24'b0, lane_sh[7:0]}  : {{24{lane_sh[7]}}, lane_sh[7:0]};
      2'b01:   ld_fmt = lat_uns ? {16'b0, lane_sh[15:0]} : {{16{lane_sh[15]}}, lane_sh[15:0]};
      default: ld_fmt = dm_rdata;
    endcase
  end

  always_comb begin
    rmw_data = dm_rdata;
    if (lat_size == 2'b00) rmw_data[{lat_off, 3'b000} +: 8] = lat_wdata[7:0];
    else if (lat_off[1])   rmw_data[31:16] = lat_wdata;
    else                   rmw_data[15:0]  = lat_wdata;
  end

  // Memory port is driven in the accept cycle so the memory samples at the same edge.
  always_comb begin
    state_nx = state;
    dm_en    = 1'b0;
    dm_we    = 1'b0;
    dm_addr  = '0;
    dm_wdata = '0;
    case (state)
      IDLE: begin
        if (accept && !misalign) begin
          dm_addr = req_addr[ADDR_W-1:2];
          if (!req_we) begin
            dm_en    = 1'b1;
            state_nx = LD_WAIT;
          end else if (word_store) begin
            dm_we    = 1'b1;
            dm_wdata = req_wdata;
          end else begin
            dm_en    = 1'b1;
            state_nx = RMW_WR;
          end
        end
      end
      LD_WAIT: state_nx = IDLE;
      RMW_WR: begin
        dm_we    = 1'b1;
        dm_addr  = lat_addr;
        dm_wdata = rmw_data;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lat_addr  <= '0;
      lat_off   <= 2'b00;
      lat_size  <= 2'b00;
      lat_uns   <= 1'b0;
      lat_wdata <= '0;
    end else if (accept) begin
      lat_addr  <= req_addr[ADDR_W-1:2];
      lat_off   <= req_addr[1:0];
      lat_size  <= req_size;
      lat_uns   <= req_unsigned;
      lat_wdata <= req_wdata[15:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ld_valid     <= 1'b0;
      ld_data      <= '0;
      err_misalign <= 1'b0;
    end else begin
      ld_valid     <= (state == LD_WAIT);
      err_misalign <= accept && misalign;
      if (state == LD_WAIT) ld_data <= ld_fmt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_load     <= '0;
      cnt_store    <= '0;
      cnt_rmw      <= '0;
      cnt_misalign <= '0;
    end else begin
      if (state == LD_WAIT) cnt_load <= cnt_load + CNT_ONE;
      if ((state == RMW_WR) || (accept && !misalign && word_store))
        cnt_store <= cnt_store + CNT_ONE;
      if (state == RMW_WR) cnt_rmw <= cnt_rmw + CNT_ONE;
      if (accept && misalign) cnt_misalign <= cnt_misalign + CNT_ONE;
    end
  end

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Directed bench for dmem_access_ctrl: behavioural memory, scoreboard queues for load results,
// memory writes and misalign pulses, and a negedge monitor that pops and compares.
module tb_dmem_access_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_unsigned = 1'b0;
  logic [15:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        ld_valid;
  logic [31:0] ld_data;
  logic        err_misalign;
  logic        dm_en;
  logic        dm_we;
  logic [13:0] dm_addr;
  logic [31:0] dm_wdata;
  logic [31:0] dm_rdata;
  logic [31:0] cnt_load, cnt_store, cnt_rmw, cnt_misalign;
  logic [1:0]  dbg_state;

  dmem_access_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .ld_valid(ld_valid), .ld_data(ld_data),
    .err_misalign(err_misalign), .dm_en(dm_en), .dm_we(dm_we),
    .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_rdata(dm_rdata),
    .cnt_load(cnt_load), .cnt_store(cnt_store), .cnt_rmw(cnt_rmw),
    .cnt_misalign(cnt_misalign), .dbg_state(dbg_state)
  );

  // Clock / reset / cycle counter
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural single-port memory: registered read, synchronous write
  logic [31:0] mem [0:16383];
  logic [31:0] mem_rd = '0;
  always @(posedge clk) begin
    if (dm_we) mem[dm_addr] <= dm_wdata;
    if (dm_en) mem_rd <= mem[dm_addr];
  end
  assign dm_rdata = mem_rd;

  // Scoreboard
  logic [31:0] exp_q[$];
  int          exp_cyc_q[$];
  logic [45:0] exp_wr_q[$];
  int          err_cyc_q[$];
  int n_vec = 0;
  int n_err = 0;
  int err_pulses = 0;
  int en_pulses = 0;
  int we_pulses = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic flag(input string name);
    n_vec++;
    n_err++;
    $display("FAIL %s: unexpected DUT output at cycle %0d", name, cyc);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Driver: issues one request at posedge+1 and pushes its expected response.
  task automatic do_req(input logic we, input logic [1:0] sz, input logic uns,
                        input logic [15:0] a, input logic [31:0] wd, input logic [31:0] exp_val);
    int   b;
    logic mis;
    logic one_cyc;
    b = 0;
    mis = (sz == 2'b11) || (sz == 2'b01 && a[0]) || (sz == 2'b10 && a[1:0] != 2'b00);
    one_cyc = mis || (we && sz == 2'b10);
    while (!req_ready && b < 20) begin
      @(posedge clk);
      #1;
      b++;
    end
    check("req_ready_wait", {63'b0, req_ready}, 64'd1);
    req_valid = 1'b1;
    req_we = we;
    req_size = sz;
    req_unsigned = uns;
    req_addr = a;
    req_wdata = wd;
    if (mis) begin
      err_cyc_q.push_back(cyc + 1);
    end else if (!we) begin
      exp_q.push_back(exp_val);
      exp_cyc_q.push_back(cyc + 2);
    end else begin
      exp_wr_q.push_back({a[15:2], exp_val});
    end
    #1;
    if (mis)
      check("accept_port_misalign", {62'b0, dm_en, dm_we}, 64'd0);
    else if (!we)
      check("accept_port_load", {48'b0, dm_en, dm_we, dm_addr}, {48'b0, 2'b10, a[15:2]});
    else if (sz == 2'b10)
      check("accept_port_word_store", {16'b0, dm_en, dm_we, dm_addr, dm_wdata},
            {16'b0, 2'b01, a[15:2], wd});
    else
      check("accept_port_rmw_read", {48'b0, dm_en, dm_we, dm_addr}, {48'b0, 2'b10, a[15:2]});
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    check("ready_after_accept", {63'b0, req_ready}, {63'b0, one_cyc});
    if (!one_cyc) begin
      @(posedge clk);
      #1;
      check("ready_second_cycle", {63'b0, req_ready}, 64'd1);
    end
  endtask

  initial begin
    int en0, we0, err0;

    // Monitor: pops and compares whenever the DUT presents an output
    fork
      forever begin
        @(negedge clk);
        if (rst_n) begin
          if (dm_en && dm_we) flag("dm_en_and_dm_we");
          if (dm_en) en_pulses++;
          if (dm_we) begin
            we_pulses++;
            if (exp_wr_q.size() == 0) flag("mem_write_unexpected");
            else check("mem_write", {18'b0, dm_addr, dm_wdata}, {18'b0, exp_wr_q.pop_front()});
          end
          if (ld_valid) begin
            if (exp_q.size() == 0) flag("ld_valid_unexpected");
            else begin
              check("ld_data", {32'b0, ld_data}, {32'b0, exp_q.pop_front()});
              check("ld_latency", 64'(cyc), 64'(exp_cyc_q.pop_front()));
            end
          end
          if (err_misalign) begin
            err_pulses++;
            if (err_cyc_q.size() == 0) flag("err_misalign_unexpected");
            else check("err_latency", 64'(cyc), 64'(err_cyc_q.pop_front()));
          end
        end
      end
    join_none

    // Reset state
    idle(2);
    check("rst_dm_en_we", {62'b0, dm_en, dm_we}, 64'd0);
    rst_n = 1'b1;
    idle(1);
    check("rst_ready", {63'b0, req_ready}, 64'd1);
    check("rst_ld", {31'b0, ld_valid, ld_data}, 64'd0);
    check("rst_err", {63'b0, err_misalign}, 64'd0);
    check("rst_counters", {cnt_load | cnt_store | cnt_rmw | cnt_misalign}, 64'd0);
    check("rst_state", {62'b0, dbg_state}, 64'd0);

    // Preload word 4 through a word store, then formatted loads
    do_req(1'b1, 2'b10, 1'b0, 16'h0010, 32'h8899AABB, 32'h8899AABB);
    do_req(1'b0, 2'b00, 1'b0, 16'h0012, 32'h0, 32'hFFFFFF99);
    do_req(1'b0, 2'b00, 1'b1, 16'h0012, 32'h0, 32'h00000099);
    do_req(1'b0, 2'b01, 1'b0, 16'h0010, 32'h0, 32'hFFFFAABB);
    do_req(1'b0, 2'b10, 1'b0, 16'h0010, 32'h0, 32'h8899AABB);

    // Sub-word stores as read-modify-write
    do_req(1'b1, 2'b00, 1'b0, 16'h0011, 32'h0000005A, 32'h88995ABB);
    idle(2);
    check("cnt_rmw_after_byte", {32'b0, cnt_rmw}, 64'd1);
    do_req(1'b0, 2'b10, 1'b0, 16'h0010, 32'h0, 32'h88995ABB);
    do_req(1'b1, 2'b01, 1'b0, 16'h0012, 32'h1234BEEF, 32'hBEEF5ABB);
    do_req(1'b0, 2'b01, 1'b1, 16'h0012, 32'h0, 32'h0000BEEF);
    do_req(1'b0, 2'b00, 1'b0, 16'h0013, 32'h0, 32'hFFFFFFBE);

    // Back-to-back word stores
    do_req(1'b1, 2'b10, 1'b0, 16'h0000, 32'h11111111, 32'h11111111);
    do_req(1'b1, 2'b10, 1'b0, 16'h0004, 32'h22222222, 32'h22222222);
    do_req(1'b1, 2'b10, 1'b0, 16'h0008, 32'h33333333, 32'h33333333);
    idle(3);
    check("cnt_store", {32'b0, cnt_store}, 64'd6);
    check("cnt_load", {32'b0, cnt_load}, 64'd7);
    check("cnt_rmw", {32'b0, cnt_rmw}, 64'd2);

    // Misaligned requests
    en0 = en_pulses;
    we0 = we_pulses;
    err0 = err_pulses;
    do_req(1'b0, 2'b10, 1'b0, 16'h0013, 32'h0, 32'h0);
    do_req(1'b1, 2'b01, 1'b0, 16'h0001, 32'hFFFF, 32'h0);
    idle(3);
    check("misalign_pulses", 64'(err_pulses - err0), 64'd2);
    check("misalign_no_port", 64'((en_pulses - en0) + (we_pulses - we0)), 64'd0);
    check("cnt_misalign", {32'b0, cnt_misalign}, 64'd2);

    // Reset while in RMW_WR aborts the write
    req_valid = 1'b1;
    req_we = 1'b1;
    req_size = 2'b00;
    req_unsigned = 1'b0;
    req_addr = 16'h0010;
    req_wdata = 32'h0;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    check("rmw_state_before_reset", {62'b0, dbg_state}, 64'd2);
    rst_n = 1'b0;
    #1;
    check("reset_drops_dm_we", {62'b0, dm_en, dm_we}, 64'd0);
    check("reset_ready", {63'b0, req_ready}, 64'd1);
    check("reset_counters", {cnt_load | cnt_store | cnt_rmw | cnt_misalign}, 64'd0);
    check("reset_ld_data", {32'b0, ld_data}, 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("ready_after_release", {63'b0, req_ready}, 64'd1);
    do_req(1'b0, 2'b10, 1'b0, 16'h0010, 32'h0, 32'hBEEF5ABB);
    idle(3);
    check("cnt_after_reset", {cnt_load, cnt_store}, {32'd1, 32'd0});

    // Drain
    idle(5);
    check("exp_q_drained", 64'(exp_q.size()), 64'd0);
    check("exp_wr_q_drained", 64'(exp_wr_q.size()), 64'd0);
    check("err_q_drained", 64'(err_cyc_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Hard time limit so the run always ends
  initial begin
    #200000;
    $display("FAIL timeout: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/dmem_access_ctrl.md
Name: dmem_access_ctrl

Overview:
- Load/store front-end sitting directly upstream of the 16K x 32 word-addressed data memory; the memory has one port, 1-cycle registered read, synchronous write and no byte enables.
- Accepts byte/halfword/word requests from the MEM pipeline stage using byte addresses.
- Drives the memory port, formats load data (lane select, sign/zero extension) and implements sub-word stores as read-modify-write.
- Flags misaligned accesses and keeps access statistics.

Parameters:
- ADDR_W, 16, byte address width; word address = addr[ADDR_W-1:2], 14 bits at default.
- DATA_W, 32, data width; fixed at 32, sub-word lanes assume it.
- CNT_W, 32, width of statistics counters.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  controller can accept; = (state==IDLE).
- req_we  in  1  1=store, 0=load.
- req_size  in  2  00 byte, 01 half, 10 word, 11 reserved.
- req_unsigned  in  1  loads: 1 zero-extend, 0 sign-extend.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  32  store data, right-justified.
- ld_valid  out  1  one-cycle pulse, load result valid.
- ld_data  out  32  formatted load result; holds until next load completes.
- err_misalign  out  1  one-cycle pulse, rejected request.
- dm_en  out  1  memory read enable.
- dm_we  out  1  memory write enable.
- dm_addr  out  14  memory word address.
- dm_wdata  out  32  memory write data.
- dm_rdata  in  32  memory read data; valid the cycle after dm_en.
- cnt_load, cnt_store, cnt_rmw, cnt_misalign  out  CNT_W  statistics counters.

Behaviour:
- Accept condition: req_valid && req_ready at posedge.
- States: IDLE, LD_WAIT, RMW_WR.
- Little-endian lanes: byte offset k maps to bits 8k+7:8k; a halfword at offset 2 maps to bits 31:16.

Alignment check (combinational on request):
- half with addr[0]=1 is misaligned.
- word with addr[1:0]!=0 is misaligned.
- size 11 is treated as misaligned.
- On a misaligned accept: dm_en=dm_we=0; err_misalign pulses the following cycle; cnt_misalign +1; state stays IDLE; no ld_valid.

Memory port drive (combinational from state and request):
- Port is driven in the accept cycle so the memory samples at the same edge.
- IDLE, aligned load: dm_en=1, dm_addr=req word address. Next state LD_WAIT. Latch offset, size and unsigned flag.
- IDLE, aligned word store: dm_we=1, dm_wdata=req_wdata. Single cycle, stays IDLE, cnt_store +1.
- IDLE, aligned byte/half store: dm_en=1 (read old word). Latch address, offset, size and wdata. Next state RMW_WR.
- LD_WAIT: select lane from dm_rdata and extend; register into ld_data; ld_valid=1 in the following cycle; go to IDLE; cnt_load +1. Load latency: result visible 2 cycles after accept.
- RMW_WR: dm_we=1, dm_addr=latched address, dm_wdata=dm_rdata with the selected lane replaced by the latched byte/half. Go to IDLE; cnt_store +1; cnt_rmw +1. Sub-word store occupies 2 cycles.
- req_ready is low in LD_WAIT and RMW_WR; requests are not accepted there.
- Back-to-back accepts are allowed from IDLE every cycle for word stores and misaligned requests.
- When not accessing: dm_en=dm_we=0, dm_addr=0, dm_wdata=0. Never assert dm_en and dm_we in the same cycle.

Counters:
- Wrap modulo 2^CNT_W.

Reset:
- Asynchronous, immediate: state=IDLE.
- ld_valid=0, ld_data=0, err_misalign=0, all counters=0.
- dm_en/dm_we fall combinationally.
- Reset during LD_WAIT discards the load with no ld_valid.
- Reset during RMW_WR aborts the write; memory is left unchanged.

Test Plan:
- Word 0x8899AABB preloaded at word 4; load byte signed addr 0x0012 -> dm_en=1/dm_addr=4 in accept cycle; ld_valid 2 cycles later with ld_data=0xFFFFFF99; same access unsigned -> 0x00000099.
- Load half signed addr 0x0010 -> 0xFFFFAABB; load word addr 0x0010 -> 0x8899AABB; req_ready low exactly 1 cycle per load.
- Store byte 0x5A at addr 0x0011 over 0x8899AABB -> read then write cycle, dm_we with dm_wdata=0x88995ABB at word 4; cnt_rmw=1; subsequent word load returns 0x88995ABB.
- Three consecutive word stores to words 0,1,2 -> three dm_we pulses in three cycles, req_ready held high, cnt_store=3.
- Load word addr 0x0013 and store half addr 0x0001 -> err_misalign pulses once each, no dm_en/dm_we, no ld_valid, cnt_misalign=2.
- Assert rst_n=0 during RMW_WR -> dm_we drops immediately; memory word unchanged; state IDLE; counters 0; req_ready=1 after release.
